// File: rtl/packet_frame_tx.sv
// Line buffer and packet framer: stores each serialized line, then emits
// SYNC0 SYNC1 row lenH lenL payload csum over a ready/valid byte link.
module packet_frame_tx #(
  parameter int         FIFO_DEPTH_BIT = 11,
  parameter int         DESC_DEPTH_BIT = 2,
  parameter logic [7:0] SYNC0          = 8'hAA,
  parameter logic [7:0] SYNC1          = 8'h55
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  input  logic [7:0] i_row_number,
  input  logic       i_tx_ready,
  output logic       o_tx_valid,
  output logic [7:0] o_tx_data,
  output logic       o_tx_last,
  output logic       o_busy,
  output logic       o_overflow
);

  localparam int PD = 1 << FIFO_DEPTH_BIT;
  localparam int DD = 1 << DESC_DEPTH_BIT;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC0, S_SYNC1, S_ROW,
    S_LENH, S_LENL, S_PAY, S_CSUM
  } state_t;

  logic [7:0]                pmem [PD];
  logic [FIFO_DEPTH_BIT-1:0] pwr, prd;
  logic [FIFO_DEPTH_BIT:0]   pcnt;
  logic [23:0]               dmem [DD];
  logic [DESC_DEPTH_BIT-1:0] dwr, drd;
  logic [DESC_DEPTH_BIT:0]   dcnt;

  logic        line_act, line_drop;
  logic [7:0]  row_q;
  logic [15:0] len_q;

  state_t      state;
  logic [7:0]  row_r, csum;
  logic [15:0] len_r, left;

  logic pfull, dfull, dempty;
  logic line_start, accept, pwe, dpush;
  logic hs, dpop, ppop;
  logic [7:0] head;

  // count MSB is set only at exactly full
  assign pfull  = pcnt[FIFO_DEPTH_BIT];
  assign dfull  = dcnt[DESC_DEPTH_BIT];
  assign dempty = (dcnt == '0);
  assign head   = pmem[prd];

  assign line_start = i_valid & ~line_act & ~line_drop;
  assign accept     = line_start & ~dfull;
  assign pwe        = i_valid & (line_act | accept) & ~pfull;
  assign dpush      = ~i_valid & line_act;

  assign hs   = o_tx_valid & i_tx_ready;
  assign dpop = (state == S_IDLE) & ~dempty;
  assign ppop = hs & (((state == S_LENL) & (len_r != 16'd0))
              | ((state == S_PAY) & (left != 16'd1)));

  always_ff @(posedge i_clk) begin
    if (pwe) pmem[pwr] <= i_data;
    if (dpush) dmem[dwr] <= {row_q, len_q};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      line_act   <= 1'b0;
      line_drop  <= 1'b0;
      row_q      <= '0;
      len_q      <= '0;
      o_overflow <= 1'b0;
      pwr        <= '0;
      prd        <= '0;
      pcnt       <= '0;
      dwr        <= '0;
      drd        <= '0;
      dcnt       <= '0;
    end else begin
      if (accept) begin
        line_act <= 1'b1;
        row_q    <= i_row_number;
        len_q    <= {15'd0, pwe};
      end else if (line_act & pwe) begin
        len_q <= len_q + 16'd1;
      end
      if (line_start & dfull) line_drop <= 1'b1;
      if (!i_valid) line_drop <= 1'b0;
      if (dpush) line_act <= 1'b0;
      if ((line_start & dfull) | (i_valid & (line_act | accept) & pfull))
        o_overflow <= 1'b1;
      if (pwe) pwr <= pwr + 1'b1;
      if (ppop) prd <= prd + 1'b1;
      pcnt <= pcnt + {{FIFO_DEPTH_BIT{1'b0}}, pwe}
                   - {{FIFO_DEPTH_BIT{1'b0}}, ppop};
      if (dpush) dwr <= dwr + 1'b1;
      if (dpop) drd <= drd + 1'b1;
      dcnt <= dcnt + {{DESC_DEPTH_BIT{1'b0}}, dpush}
                   - {{DESC_DEPTH_BIT{1'b0}}, dpop};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      o_tx_valid <= 1'b0;
      o_tx_data  <= '0;
      o_tx_last  <= 1'b0;
      o_busy     <= 1'b0;
      row_r      <= '0;
      len_r      <= '0;
      left       <= '0;
      csum       <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (!dempty) begin
          {row_r, len_r} <= dmem[drd];
          csum       <= '0;
          state      <= S_SYNC0;
          o_tx_valid <= 1'b1;
          o_tx_data  <= SYNC0;
          o_busy     <= 1'b1;
        end
        S_SYNC0: if (hs) begin
          state     <= S_SYNC1;
          o_tx_data <= SYNC1;
        end
        S_SYNC1: if (hs) begin
          state     <= S_ROW;
          o_tx_data <= row_r;
        end
        S_ROW: if (hs) begin
          csum      <= csum ^ o_tx_data;
          state     <= S_LENH;
          o_tx_data <= len_r[15:8];
        end
        S_LENH: if (hs) begin
          csum      <= csum ^ o_tx_data;
          state     <= S_LENL;
          o_tx_data <= len_r[7:0];
        end
        S_LENL: if (hs) begin
          csum <= csum ^ o_tx_data;
          if (len_r == 16'd0) begin
            state     <= S_CSUM;
            o_tx_data <= csum ^ o_tx_data;
            o_tx_last <= 1'b1;
          end else begin
            state     <= S_PAY;
            o_tx_data <= head;
            left      <= len_r;
          end
        end
        S_PAY: if (hs) begin
          csum <= csum ^ o_tx_data;
          left <= left - 16'd1;
          if (left == 16'd1) begin
            state     <= S_CSUM;
            o_tx_data <= csum ^ o_tx_data;
            o_tx_last <= 1'b1;
          end else begin
            o_tx_data <= head;
          end
        end
        S_CSUM: if (hs) begin
          state      <= S_IDLE;
          o_tx_valid <= 1'b0;
          o_tx_data  <= '0;
          o_tx_last  <= 1'b0;
          o_busy     <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_frame_tx.sv
// Directed bench for packet_frame_tx: expected frames are queued as lines
// are driven and compared byte by byte as the DUT hands them over.
module tb_packet_frame_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vld = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] row = '0;
  logic       rdy = 1'b0;

  logic       tv, tl, busy, ovf;
  logic [7:0] td;
  logic       sv, sl, sbusy, sovf;
  logic [7:0] sd;

  int checks = 0;
  int failures = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] pl[$];
  bit         mon1 = 1'b0;

  always #5 clk = ~clk;

  packet_frame_tx dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(vld), .i_data(din),
    .i_row_number(row), .i_tx_ready(rdy),
    .o_tx_valid(tv), .o_tx_data(td),
    .o_tx_last(tl), .o_busy(busy),
    .o_overflow(ovf)
  );

  packet_frame_tx #(.FIFO_DEPTH_BIT(2)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(vld), .i_data(din),
    .i_row_number(row), .i_tx_ready(rdy),
    .o_tx_valid(sv), .o_tx_data(sd),
    .o_tx_last(sl), .o_busy(sbusy),
    .o_overflow(sovf)
  );

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] pd0;
  logic       pl0, ps0, aft0;

  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      ps0  = 1'b0;
      aft0 = 1'b0;
    end else begin
      if (ps0) begin
        chk("hold_data", {8'd0, td}, {8'd0, pd0});
        chk("hold_last", {15'd0, tl}, {15'd0, pl0});
      end
      if (aft0) chk("idle_gap", {15'd0, tv}, 16'd0);
      aft0 = tv & rdy & tl;
      ps0  = tv & ~rdy;
      pd0  = td;
      pl0  = tl;
      if (tv && rdy) begin
        checks++;
        assert (q0.size() != 0) else begin
          failures++;
          $error("FAIL tx0_extra observed=%0h expected=none", {tl, td});
        end
        if (q0.size() != 0) begin
          e = q0.pop_front();
          chk("tx0", {7'd0, tl, td}, {7'd0, e});
        end
      end
      if (mon1 && sv && rdy) begin
        checks++;
        assert (q1.size() != 0) else begin
          failures++;
          $error("FAIL tx1_extra observed=%0h expected=none", {sl, sd});
        end
        if (q1.size() != 0) begin
          e = q1.pop_front();
          chk("tx1", {7'd0, sl, sd}, {7'd0, e});
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_line(input logic [7:0] r, input int n,
                           input logic [7:0] base, input bit inc);
    logic [7:0] d;
    pl.delete();
    for (int i = 0; i < n; i++) begin
      d = inc ? base + 8'(i) : base;
      pl.push_back(d);
      vld = 1'b1;
      din = d;
      row = (i == 0) ? r : 8'hFF;
      cyc(1);
    end
    vld = 1'b0;
    din = '0;
  endtask

  task automatic exp_pkt(input bit sel, input logic [7:0] r);
    logic [7:0]  cs;
    logic [15:0] n;
    logic [8:0]  b[$];
    n  = 16'(pl.size());
    cs = r ^ n[15:8] ^ n[7:0];
    b.push_back({1'b0, 8'hAA});
    b.push_back({1'b0, 8'h55});
    b.push_back({1'b0, r});
    b.push_back({1'b0, n[15:8]});
    b.push_back({1'b0, n[7:0]});
    foreach (pl[i]) begin
      b.push_back({1'b0, pl[i]});
      cs ^= pl[i];
    end
    b.push_back({1'b1, cs});
    foreach (b[i]) begin
      if (sel) q1.push_back(b[i]);
      else q0.push_back(b[i]);
    end
  endtask

  task automatic drain(input string tag, input bit tog);
    int n = 0;
    while ((q0.size() != 0 || (mon1 && q1.size() != 0)) && n < 3000) begin
      if (tog) rdy = ~rdy;
      cyc(1);
      n++;
    end
    checks++;
    assert (n < 3000) else begin
      failures++;
      $error("FAIL %s_timeout observed=%0d expected=<3000", tag, n);
    end
    cyc(2);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    cyc(3);
    chk("rst_valid", {15'd0, tv}, 16'd0);
    chk("rst_data", {8'd0, td}, 16'd0);
    chk("rst_last", {15'd0, tl}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_ovf", {15'd0, ovf}, 16'd0);
    rst_n = 1'b1;
    cyc(2);

    rdy = 1'b1;
    send_line(8'd5, 36, 8'h00, 1'b1);
    exp_pkt(1'b0, 8'd5);
    cyc(1);
    chk("lat_c1", {15'd0, tv}, 16'd0);
    cyc(1);
    chk("lat_c2", {15'd0, tv}, 16'd1);
    chk("busy_on", {15'd0, busy}, 16'd1);
    drain("t1", 1'b0);
    chk("t1_ovf", {15'd0, ovf}, 16'd0);
    chk("busy_off", {15'd0, busy}, 16'd0);

    rdy = 1'b0;
    send_line(8'd5, 36, 8'h00, 1'b1);
    exp_pkt(1'b0, 8'd5);
    drain("t2", 1'b1);
    rdy = 1'b0;
    cyc(1);

    send_line(8'd89, 9, 8'h11, 1'b0);
    exp_pkt(1'b0, 8'd89);
    cyc(1);
    send_line(8'd0, 9, 8'h11, 1'b0);
    exp_pkt(1'b0, 8'd0);
    cyc(5);
    rdy = 1'b1;
    drain("t3", 1'b0);
    chk("t3_ovf", {15'd0, ovf}, 16'd0);

    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    rdy  = 1'b0;
    mon1 = 1'b1;
    send_line(8'd7, 6, 8'h01, 1'b1);
    exp_pkt(1'b0, 8'd7);
    pl = pl[0:3];
    exp_pkt(1'b1, 8'd7);
    cyc(3);
    chk("t4_small_ovf", {15'd0, sovf}, 16'd1);
    chk("t4_main_ovf", {15'd0, ovf}, 16'd0);
    rdy = 1'b1;
    drain("t4", 1'b0);
    mon1 = 1'b0;

    // first line goes straight into the FSM, so the sixth finds 4 queued
    rdy = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      send_line(8'(i), 1, 8'(i), 1'b0);
      if (i <= 5) exp_pkt(1'b0, 8'(i));
      cyc(1);
    end
    cyc(2);
    chk("t5_ovf", {15'd0, ovf}, 16'd1);
    rdy = 1'b1;
    drain("t5", 1'b0);

    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    rdy = 1'b1;
    send_line(8'd3, 20, 8'h40, 1'b1);
    exp_pkt(1'b0, 8'd3);
    n = 0;
    while (q0.size() > 15 && n < 200) begin
      cyc(1);
      n++;
    end
    chk("t6_wait", {15'd0, n < 200}, 16'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {15'd0, tv}, 16'd0);
    chk("t6_rst_data", {8'd0, td}, 16'd0);
    chk("t6_rst_last", {15'd0, tl}, 16'd0);
    chk("t6_rst_busy", {15'd0, busy}, 16'd0);
    q0.delete();
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    send_line(8'd9, 3, 8'hA1, 1'b1);
    exp_pkt(1'b0, 8'd9);
    drain("t6", 1'b0);
    chk("t6_ovf", {15'd0, ovf}, 16'd0);
    chk("t6_qempty", 16'(q0.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
